// File: rtl/mem_bus_arbiter.sv
// Purpose: shares one D-cache bus between fetch (ibus) and MEM (dbus); one outstanding transaction. Option MEM_ARB_RR_EN: round-robin on conflict.
// Latency: request seen in IDLE -> oreq.valid next cycle; requester ok/data pass through in the oresp.data_ok cycle.
// Backpressure: requesters hold valid until data_ok; oreq is held until addr_ok; no new grant until the cycle after completion.
package common;
    typedef logic [63:0] addr_t;
    typedef logic [63:0] word_t;
    typedef logic [31:0] u32;
    typedef logic [7:0]  strobe_t;
    typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2, MSIZE8 = 3'd3} msize_t;

    typedef struct packed {
        logic  valid;
        addr_t addr;
    } ibus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u32   data;
    } ibus_resp_t;

    typedef struct packed {
        logic    valid;
        addr_t   addr;
        msize_t  size;
        strobe_t strobe;
        word_t   data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;
endpackage

module mem_bus_arbiter
    import common::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output dbus_req_t  oreq,
    input  dbus_resp_t oresp
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;
    typedef enum logic {GNT_I = 1'b0, GNT_D = 1'b1} gnt_t;

    state_t    state_q, state_d;
    gnt_t      gnt_q, gnt_d;
    dbus_req_t req_q, req_d;
    logic      half_q, half_d;
    logic      complete;
    logic      pick_d;

`ifdef MEM_ARB_RR_EN
    logic prefer_i_q, prefer_i_d;

    // Pointer favours whichever side lost the previous grant.
    always_comb pick_d = dreq.valid & (~ireq.valid | ~prefer_i_q);
`else
    always_comb pick_d = dreq.valid;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            gnt_q   <= GNT_I;
            req_q   <= '0;
            half_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            req_q   <= req_d;
            half_q  <= half_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) prefer_i_q <= 1'b0;
        else         prefer_i_q <= prefer_i_d;
    end
`endif

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        req_d    = req_q;
        half_d   = half_q;
        complete = 1'b0;
`ifdef MEM_ARB_RR_EN
        prefer_i_d = prefer_i_q;
`endif
        oreq       = req_q;
        oreq.valid = 1'b0;
        iresp      = '0;
        dresp      = '0;

        case (state_q)
            S_IDLE: begin
                if (ireq.valid | dreq.valid) begin
                    state_d = S_REQ;
                    if (pick_d) begin
                        gnt_d = GNT_D;
                        req_d = dreq;
                    end else begin
                        gnt_d  = GNT_I;
                        req_d  = {ireq.valid, ireq.addr, MSIZE4, 8'b0, 64'b0};
                        half_d = ireq.addr[2];
                    end
`ifdef MEM_ARB_RR_EN
                    prefer_i_d = pick_d;
`endif
                end
            end
            S_REQ: begin
                oreq.valid = req_q.valid;
                if (oresp.addr_ok) begin
                    if (oresp.data_ok) begin
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (oresp.data_ok) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // addr_ok is reported upstream only together with data_ok.
        if (complete) begin
            if (gnt_q == GNT_D) begin
                dresp.addr_ok = 1'b1;
                dresp.data_ok = 1'b1;
                dresp.data    = oresp.data;
            end else begin
                iresp.addr_ok = 1'b1;
                iresp.data_ok = 1'b1;
                iresp.data    = half_q ? oresp.data[63:32] : oresp.data[31:0];
            end
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised bench for mem_bus_arbiter: transaction-level bus model, response scoreboard, directed reset/spurious cases.
module tb_mem_bus_arbiter;
    import common::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    dbus_req_t  oreq;
    dbus_resp_t oresp;

    mem_bus_arbiter dut (
        .clk   (clk),
        .resetn(resetn),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .oreq  (oreq),
        .oresp (oresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit    is_d;
        word_t data;
    } exp_t;

    exp_t      sb_q[$];
    bit        done_seq[$];
    int        n_cmp = 0;
    int        n_bad = 0;
    bit        mon_en = 0;
    bit        exp_ovld = 0;
    bit        exp_cmp = 0;
    dbus_req_t exp_oreq;
    exp_t      e_mon;

    task automatic chk(input string name, input logic [139:0] act, input logic [139:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Downstream memory contents as a plain function of the address.
    function automatic word_t memdata(input addr_t a);
        return {a[31:0] ^ 32'hC3A5_5A3C, a[34:3] + 32'h1357_9BDF};
    endfunction

    // Monitor: per-cycle oreq check, scoreboard pop on any completion.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_ovld) chk("oreq", oreq, exp_oreq);
                else          chk("oreq_valid_low", oreq.valid, 1'b0);
                if (exp_cmp || iresp.data_ok || dresp.data_ok) begin
                    chk("completion_timing", iresp.data_ok | dresp.data_ok, exp_cmp);
                    if (sb_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL sb_empty: response seen with no expected transaction");
                    end else begin
                        e_mon = sb_q.pop_front();
                        done_seq.push_back(e_mon.is_d);
                        if (e_mon.is_d) begin
                            chk("dresp", dresp, {1'b1, 1'b1, e_mon.data});
                            chk("iresp_other_zero", iresp, 0);
                        end else begin
                            chk("iresp", iresp, {1'b1, 1'b1, e_mon.data[31:0]});
                            chk("dresp_other_zero", dresp, 0);
                        end
                    end
                end else begin
                    chk("iresp_zero", iresp, 0);
                    chk("dresp_zero", dresp, 0);
                end
            end
        end
    end

    bit        i_pend, d_pend, busy, acc, cur_d, win_d, pref_i, stop_new;
    addr_t     i_addr;
    dbus_req_t d_r, cur_req;
    int        a_wait, d_wait, n_grant;
    word_t     w;
    bit        exp_seq[3];

    initial begin
        ireq   = '0;
        dreq   = '0;
        oresp  = '0;
        i_pend = 0; d_pend = 0; busy = 0; acc = 0; pref_i = 0; stop_new = 0;
        n_grant = 0;
        d_r = '0;
`ifdef MEM_ARB_RR_EN
        exp_seq[0] = 1; exp_seq[1] = 0; exp_seq[2] = 1;
`else
        exp_seq[0] = 1; exp_seq[1] = 1; exp_seq[2] = 1;
`endif
        #12;
        chk("reset_oreq", oreq, 0);
        chk("reset_iresp", iresp, 0);
        chk("reset_dresp", dresp, 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            stop_new = (c >= 2900);
            if (!stop_new && !i_pend && (n_grant < 3 || $urandom_range(3) == 0)) begin
                i_pend = 1;
                i_addr = {$urandom, $urandom};
            end
            if (!stop_new && !d_pend && (n_grant < 3 || $urandom_range(3) == 0)) begin
                d_pend   = 1;
                d_r.addr = {$urandom, $urandom};
                d_r.size = msize_t'($urandom_range(3));
                d_r.strobe = 8'($urandom);
                d_r.data = {$urandom, $urandom};
            end
            ireq.valid = i_pend;
            ireq.addr  = i_pend ? i_addr : {$urandom, $urandom};
            d_r.valid  = 1'b1;
            dreq       = d_r;
            dreq.valid = d_pend;
            oresp.addr_ok = 1'b0;
            oresp.data_ok = 1'b0;
            oresp.data    = {$urandom, $urandom};
            exp_ovld = 0;
            exp_cmp  = 0;

            if (!busy) begin
                if ($urandom_range(3) == 0) oresp.data_ok = 1'b1;
                if (i_pend || d_pend) begin
`ifdef MEM_ARB_RR_EN
                    win_d = d_pend && (!i_pend || !pref_i);
`else
                    win_d = d_pend;
`endif
                    pref_i  = win_d;
                    cur_d   = win_d;
                    cur_req = win_d ? d_r : {1'b1, i_addr, MSIZE4, 8'h00, 64'h0};
                    w       = memdata(cur_req.addr);
                    if (!win_d) w = {32'h0, i_addr[2] ? w[63:32] : w[31:0]};
                    sb_q.push_back('{is_d: win_d, data: w});
                    a_wait = $urandom_range(2);
                    d_wait = $urandom_range(2);
                    acc  = 0;
                    busy = 1;
                    n_grant++;
                end
            end else if (!acc) begin
                exp_ovld = 1;
                exp_oreq = cur_req;
                if (a_wait == 0) begin
                    oresp.addr_ok = 1'b1;
                    if (d_wait == 0) begin
                        oresp.data_ok = 1'b1;
                        oresp.data    = memdata(cur_req.addr);
                        exp_cmp = 1;
                        busy    = 0;
                        if (cur_d) d_pend = 0; else i_pend = 0;
                    end else begin
                        acc = 1;
                    end
                end else begin
                    a_wait--;
                end
            end else begin
                d_wait--;
                if (d_wait == 0) begin
                    oresp.data_ok = 1'b1;
                    oresp.data    = memdata(cur_req.addr);
                    exp_cmp = 1;
                    busy    = 0;
                    if (cur_d) d_pend = 0; else i_pend = 0;
                end
            end
            if (c == 0) mon_en = 1;
        end
        @(negedge clk);
        mon_en = 0;
        chk("scoreboard_drained", sb_q.size(), 0);
        chk("busy_drained", busy, 0);
        if (done_seq.size() >= 3) begin
            for (int k = 0; k < 3; k++) chk($sformatf("conflict_order_%0d", k), done_seq[k], exp_seq[k]);
        end else begin
            n_cmp++;
            n_bad++;
            $display("FAIL conflict_order: only %0d completions, need 3", done_seq.size());
        end

        // Store granted, accepted, then reset while awaiting data_ok.
        @(posedge clk); #1;
        ireq = '0;
        dreq = {1'b1, 64'h0000_0000_8000_1000, MSIZE4, 8'h0F, 64'h0000_0000_DEAD_BEEF};
        oresp = '0;
        @(posedge clk); #1;
        chk("rst_test_oreq", oreq, dreq);
        oresp.addr_ok = 1'b1;
        @(posedge clk); #1;
        oresp = '0;
        chk("resp_state_oreq_low", oreq.valid, 1'b0);
        chk("resp_state_dresp_zero", dresp, 0);
        resetn = 1'b0;
        #1;
        chk("async_rst_oreq", oreq, 0);
        chk("async_rst_dresp", dresp, 0);
        chk("async_rst_iresp", iresp, 0);
        dreq.valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        oresp = {1'b1, 1'b1, 64'h1111_2222_3333_4444};
        #1;
        chk("stray_data_ok_dresp", dresp, 0);
        chk("stray_data_ok_iresp", iresp, 0);
        @(posedge clk); #1;
        oresp = '0;
        chk("idle_after_stray_oreq", oreq.valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares one downstream data-cache bus (`dbus_req_t`/`dbus_resp_t`) between the fetch stage's instruction bus and the memory stage's data bus. Registers the granted request, converts instruction requests to 4-byte data requests, and sequences a single outstanding transaction through the addr_ok/data_ok handshake. Responses are routed back only to the granted requester. Sits between the pipeline (IF/MEM) and the D-cache/uncached bridge.

## Interface
- No parameters; all widths come from `common` (`addr_t`/`word_t` 64 b, `u32` instruction data).
- `clk`  in  1  single clock, all state on rising edge.
- `resetn`  in  1  **reset is asynchronous and active-low**.
- `ireq`  in  `ibus_req_t`  fetch request; requester holds it stable until `iresp.data_ok`.
- `iresp`  out  `ibus_resp_t`  fetch response.
- `dreq`  in  `dbus_req_t`  data request; requester holds it stable until `dresp.data_ok`.
- `dresp`  out  `dbus_resp_t`  data response.
- `oreq`  out  `dbus_req_t`  downstream request, driven only from internal register.
- `oresp`  in  `dbus_resp_t`  downstream response.

## Operation
- States: IDLE, REQ (oreq.valid high, awaiting oresp.addr_ok), RESP (awaiting oresp.data_ok). Grant register `gnt` ∈ {I, D}.
- IDLE: if any requester valid, choose winner, latch request into `req_q`, set `gnt`, go REQ. Otherwise stay.
- Fixed priority (default): D beats I when both valid (MEM stage is older).
- I conversion on latch: `{ireq.valid, ireq.addr, MSIZE4, 8'b0, 64'b0}`; `ireq.addr[2]` saved for half select.
- REQ: `oreq = req_q`. On `addr_ok & data_ok` → complete, IDLE. On `addr_ok` only → RESP. Else stay.
- RESP: `oreq.valid` = 0 (other fields hold). On `data_ok` → complete, IDLE.
- Complete cycle: granted requester sees `addr_ok=1`, `data_ok=1`, data = `oresp.data` (D) or 32-bit half selected by saved addr[2] (I). Non-granted requester sees all-zero response.
- Outside complete cycle both requester responses are all zero (addr_ok is reported only with data_ok; requester holds valid throughout).
- Requester dropping valid after grant: downstream transaction still completes; response is still pulsed; requester ignores it. No abort.
- No new grant in the completion cycle; next grant earliest the following IDLE cycle.

## Timing
- Reset (async assert): state IDLE, `gnt`=I, `req_q`=0, `oreq`=0, `iresp`=0, `dresp`=0, RR pointer (if built) → D-first. Reset mid-transaction abandons it; `oreq.valid` drops immediately.
- Latency: request valid at cycle 0 (IDLE) → `oreq.valid` at cycle 1 → requester data_ok in the same cycle as `oresp.data_ok` (combinational pass-through of ok/data, registered gnt/addr[2]).
- Minimum occupancy 2 cycles/transaction (IDLE latch + REQ with coincident addr_ok/data_ok); peak throughput one transaction per 2 cycles.
- `oresp.data_ok` seen in IDLE is ignored (not forwarded).
- `req_q` does not sample inputs outside IDLE.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin on conflict; 1-bit pointer prefers the requester not granted last time whenever both are valid; single requester always wins. Pointer updates at grant.
- Undefined: fixed D-over-I priority; no pointer state.

## Test plan
- Lone fetch: ireq addr 0x8000_0004, downstream addr_ok cycle 2, data_ok cycle 4 with data 0x1111_2222_3333_4444 → oreq size MSIZE4, strobe 0; iresp.data_ok cycle 4 with data 0x1111_2222; dresp stays 0.
- Lone store: dreq addr 0x8000_1000, strobe 0x0F, data 0xDEAD_BEEF, addr_ok+data_ok same cycle → oreq mirrors dreq exactly; dresp ok pulse 1 cycle; FSM back to IDLE next cycle, 2-cycle occupancy.
- Conflict: ireq and dreq valid continuously, 3 transactions → fixed: D,D,D (I starves while D valid); with `MEM_ARB_RR_EN`: D,I,D.
- Back-to-back: dreq completes, ireq already waiting → ireq granted in the IDLE cycle after completion, oreq.valid low exactly that one cycle.
- Reset mid-RESP: assert resetn=0 while awaiting data_ok → oreq.valid and all responses 0 immediately; stray data_ok after release not forwarded.
- Spurious downstream: oresp.data_ok=1 in IDLE with no requests → iresp/dresp remain 0, state IDLE.
